// File: rtl/uart_word_framer.sv
// Word-to-byte framer feeding a UART transmitter: FIFO-buffered 16-bit words go out as SYNC, HI, LO frames.
// Define UART_WORD_FRAMER_CHECKSUM_EN to append a fourth XOR checksum byte to every frame.
module uart_word_framer #(
    parameter logic [7:0] SYNC_BYTE  = 8'h80,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  tx_byte,
    output logic        transmit,
    input  logic        is_transmitting,
    output logic        busy,
    output logic [7:0]  frames_sent
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef UART_WORD_FRAMER_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;

    function automatic logic [7:0] frame_checksum(input logic [15:0] w);
        return SYNC_BYTE ^ w[15:8] ^ w[7:0];
    endfunction
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] w);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = w[15:8];
            2'd2:    b = w[7:0];
`ifdef UART_WORD_FRAMER_CHECKSUM_EN
            2'd3:    b = frame_checksum(w);
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE, NEXT} state_t;

    state_t            state_r, next_state_s;
    logic [15:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r, count_next_s;
    logic              push_s, pop_s, frame_done_s;
    logic [15:0]       word_r, word_next_s;
    logic [1:0]        idx_r, idx_next_s;
    logic [7:0]        tx_byte_r;
    logic              transmit_r, busy_r;
    logic [7:0]        frames_r;

    assign word_ready  = (count_r != CNT_W'(FIFO_DEPTH));
    assign push_s      = word_valid && word_ready;
    assign tx_byte     = tx_byte_r;
    assign transmit    = transmit_r;
    assign busy        = busy_r;
    assign frames_sent = frames_r;

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Framing FSM next state; LOAD is only reachable with a non-empty FIFO
    always_comb begin
        next_state_s = state_r;
        idx_next_s   = idx_r;
        word_next_s  = word_r;
        pop_s        = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != {CNT_W{1'b0}}) next_state_s = LOAD;
                else                          next_state_s = IDLE;
            end
            LOAD: begin
                pop_s        = 1'b1;
                word_next_s  = mem_r[rd_ptr_r];
                idx_next_s   = 2'd0;
                next_state_s = SEND;
            end
            SEND: next_state_s = WAIT_BUSY;
            WAIT_BUSY: begin
                if (is_transmitting) next_state_s = WAIT_DONE;
                else                 next_state_s = WAIT_BUSY;
            end
            WAIT_DONE: begin
                if (!is_transmitting) next_state_s = NEXT;
                else                  next_state_s = WAIT_DONE;
            end
            NEXT: begin
                if (idx_r == LAST_IDX) begin
                    frame_done_s = 1'b1;
                    if (count_r != {CNT_W{1'b0}}) next_state_s = LOAD;
                    else                          next_state_s = IDLE;
                end else begin
                    idx_next_s   = idx_r + 2'd1;
                    next_state_s = SEND;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= word_in;
    end

    // State, FIFO pointers and registered outputs; transmit/tx_byte load on entry to SEND
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            word_r     <= 16'h0000;
            idx_r      <= 2'd0;
            tx_byte_r  <= 8'h00;
            transmit_r <= 1'b0;
            busy_r     <= 1'b0;
            frames_r   <= 8'h00;
        end else begin
            state_r    <= next_state_s;
            count_r    <= count_next_s;
            word_r     <= word_next_s;
            idx_r      <= idx_next_s;
            transmit_r <= (next_state_s == SEND);
            busy_r     <= (next_state_s != IDLE) || (count_next_s != {CNT_W{1'b0}});
            if (push_s)                wr_ptr_r  <= wr_ptr_r + PTR_W'(1);
            if (pop_s)                 rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
            if (next_state_s == SEND)  tx_byte_r <= frame_byte(idx_next_s, word_next_s);
            if (frame_done_s)          frames_r  <= frames_r + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_word_framer.sv
// Scoreboard bench for uart_word_framer: expected frame bytes are queued on word acceptance and
// compared by a UART transmitter model whenever the framer pulses transmit.
module tb_uart_word_framer;
    localparam logic [7:0] SYNC = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        is_transmitting;
    logic        busy;
    logic [7:0]  frames_sent;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         tx_pulses = 0;
    int         exp_frames = 0;
    int         busy_len = 10;
    bit         stall = 1'b0;
    int         base;

    uart_word_framer #(.SYNC_BYTE(SYNC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .tx_byte(tx_byte), .transmit(transmit),
        .is_transmitting(is_transmitting), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // UART transmitter model: goes busy on a transmit pulse, stays busy while stalled
    initial begin
        int cnt;
        is_transmitting = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (transmit === 1'b1) begin
                tx_pulses++;
                check_eq("tx_while_busy", {31'd0, is_transmitting}, 32'd0);
                if (exp_q.size() == 0) check_eq("tx_unexpected", 32'd1, 32'd0);
                else                   check_eq("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
                is_transmitting = 1'b1;
                cnt = busy_len;
            end else if (is_transmitting && !stall) begin
                if (cnt <= 1) is_transmitting = 1'b0;
                else          cnt--;
            end
        end
    end

    task automatic push_word(input logic [15:0] w);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        word_in = w;
        word_valid = 1'b1;
        while (!acc && n < 400) begin
            acc = word_ready;
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        if (!acc) begin
            check_eq("push_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(SYNC);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
`ifdef UART_WORD_FRAMER_CHECKSUM_EN
            exp_q.push_back(SYNC ^ w[15:8] ^ w[7:0]);
`endif
            exp_frames++;
        end
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
        check_eq({tag, "_frames"}, {24'd0, frames_sent}, exp_frames & 32'hFF);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
`ifdef UART_WORD_FRAMER_CHECKSUM_EN
        int bpf = 4;
`else
        int bpf = 3;
`endif
        rst = 1'b1;
        word_in = 16'h0000;
        word_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_word_ready", {31'd0, word_ready}, 32'd1);
        check_eq("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check_eq("rst_transmit", {31'd0, transmit}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_frames", {24'd0, frames_sent}, 32'd0);

        // Single word and first-byte latency: transmit in the third cycle after accept
        base = tx_pulses;
        word_in = 16'hA55A;
        word_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(SYNC); exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
`ifdef UART_WORD_FRAMER_CHECKSUM_EN
        exp_q.push_back(SYNC ^ 8'hA5 ^ 8'h5A);
`endif
        exp_frames++;
        @(negedge clk);
        word_valid = 1'b0;
        check_eq("lat_c1_transmit", {31'd0, transmit}, 32'd0);
        @(negedge clk);
        check_eq("lat_c2_transmit", {31'd0, transmit}, 32'd0);
        @(negedge clk);
        check_eq("lat_c3_transmit", {31'd0, transmit}, 32'd1);
        check_eq("lat_c3_tx_byte", {24'd0, tx_byte}, {24'd0, SYNC});
        wait_idle("single");
        check_eq("single_pulses", tx_pulses - base, bpf);

        // Data bytes equal to sync are not escaped
        push_word(16'h8080);
        wait_idle("sync_data");

        // FIFO fill behind a stalled byte, then release
        stall = 1'b1;
        base = tx_pulses;
        push_word(16'h00FF);
        n = 0;
        while (tx_pulses == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("stall_started", {31'd0, is_transmitting}, 32'd1);
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            check_eq("fill_ready", {31'd0, word_ready}, 32'd1);
            push_word(i[15:0]);
        end
        check_eq("fill_full", {31'd0, word_ready}, 32'd0);
        word_in = 16'h0005;
        word_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("fill_still_full", {31'd0, word_ready}, 32'd0);
        stall = 1'b0;
        push_word(16'h0005);
        wait_idle("fill");

        // Continuous offer: pushes coincide with LOAD pops at partial and full occupancy
        busy_len = 3;
        for (int i = 0; i < 12; i++) push_word(16'h1000 + i[15:0]);
        wait_idle("stream");

        // Reset during WAIT_DONE of the high byte with two words queued
        busy_len = 10;
        base = tx_pulses;
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        n = 0;
        while (tx_pulses < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_eq("mid_in_byte", {31'd0, is_transmitting}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        exp_frames = 0;
        @(negedge clk);
        rst = 1'b0;
        base = tx_pulses;
        repeat (40) @(negedge clk);
        check_eq("mid_no_transmit", tx_pulses - base, 32'd0);
        check_eq("mid_word_ready", {31'd0, word_ready}, 32'd1);
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_frames", {24'd0, frames_sent}, 32'd0);
        check_eq("mid_tx_byte", {24'd0, tx_byte}, 32'd0);

        // Frame counter wrap
        busy_len = 2;
        for (int i = 0; i < 255; i++) push_word(16'h4000 + i[15:0]);
        wait_idle("wrap255");
        check_eq("wrap_255", {24'd0, frames_sent}, 32'd255);
        push_word(16'hBEEF);
        wait_idle("wrap256");
        check_eq("wrap_zero", {24'd0, frames_sent}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
